// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared widths, lane array types and index limits for the CBFP denormaliser.
package cbfp_pkg;
  localparam int ARRAY_SIZE = 16;
  localparam int DIN_SIZE = 11;
  localparam int DOUT_SIZE = 13;
  localparam int IDX_SIZE = 5;
  localparam int BASE = 4;
  localparam int BLK_BEATS = 4;
  localparam int MAX_IDX = 22;
  localparam int SAT_W = 7;
  typedef logic signed [DIN_SIZE-1:0] din_t;
  typedef logic signed [DOUT_SIZE-1:0] dout_t;
  typedef din_t [ARRAY_SIZE-1:0] din_arr_t;
  typedef dout_t [ARRAY_SIZE-1:0] dout_arr_t;
  typedef logic [IDX_SIZE-1:0] idx_t;
endpackage

// File: rtl/cbfp_denorm_if.sv
// cbfp_denorm_if: beat bus between the CBFP normaliser, the denormaliser and the next butterfly.
// CBFP_DENORM_SATCNT_EN adds the per-block saturation count.
interface cbfp_denorm_if;
  import cbfp_pkg::*;
  logic valid_in;
  din_arr_t din;
  idx_t blk_idx_in;
  logic valid_out;
  logic blk_start_out;
  dout_arr_t dout;
  idx_t blk_idx_out;
  logic frame_err;
`ifdef CBFP_DENORM_SATCNT_EN
  logic [SAT_W-1:0] sat_cnt;
  modport master(output valid_in, din, blk_idx_in,
                 input valid_out, blk_start_out, dout, blk_idx_out, frame_err, sat_cnt);
  modport slave(input valid_in, din, blk_idx_in,
                output valid_out, blk_start_out, dout, blk_idx_out, frame_err, sat_cnt);
`else
  modport master(output valid_in, din, blk_idx_in,
                 input valid_out, blk_start_out, dout, blk_idx_out, frame_err);
  modport slave(input valid_in, din, blk_idx_in,
                output valid_out, blk_start_out, dout, blk_idx_out, frame_err);
`endif
endinterface

// File: rtl/cbfp_lane_shift.sv
// cbfp_lane_shift: one lane of denormalisation, left shift with saturation or round-half-up right shift.
module cbfp_lane_shift
  import cbfp_pkg::*;
(
  input  din_t  i_din,
  input  idx_t  i_idx,
  output dout_t o_dout,
  output logic  o_sat
);
  // 24 bits covers the rounding constant for the largest right shift (18)
  localparam int W = 24;
  localparam logic signed [W-1:0] MAX_O = W'((1 << (DOUT_SIZE-1)) - 1);
  localparam logic signed [W-1:0] MIN_O = W'(-(1 << (DOUT_SIZE-1)));
  idx_t w_idx;
  logic signed [W-1:0] w_wide;
  logic signed [W-1:0] w_res;
  assign w_idx = (i_idx > idx_t'(MAX_IDX)) ? idx_t'(MAX_IDX) : i_idx;
  assign w_wide = W'(i_din);
  assign w_res = (w_idx <= idx_t'(BASE)) ? (w_wide <<< (idx_t'(BASE) - w_idx))
               : ((w_wide + (W'(1) <<< (w_idx - idx_t'(BASE) - 1'b1))) >>> (w_idx - idx_t'(BASE)));
  assign o_sat = (w_res > MAX_O) || (w_res < MIN_O);
  assign o_dout = o_sat ? (w_res[W-1] ? MIN_O[DOUT_SIZE-1:0] : MAX_O[DOUT_SIZE-1:0]) : w_res[DOUT_SIZE-1:0];
endmodule

// File: rtl/cbfp_denorm.sv
// cbfp_denorm: restores CBFP block mantissas to a common fixed-point scale, 2-cycle pipeline.
// CBFP_DENORM_SATCNT_EN adds sat_cnt, the count of saturated lanes in the current block.
module cbfp_denorm
  import cbfp_pkg::*;
(
  input logic clk,
  input logic rst,
  cbfp_denorm_if.slave bus
);
  localparam int CNT_W = $clog2(BLK_BEATS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  idx_t r_idx;
  logic r1_valid;
  logic r1_first;
  din_arr_t r1_din;
  idx_t r1_idx;
  idx_t w_idx;
  dout_arr_t w_dout;
  logic [ARRAY_SIZE-1:0] w_sat;
  logic w_last;
  // the index is only sampled on the first beat of a block
  assign w_idx = (r_state == IDLE) ? bus.blk_idx_in : r_idx;
  assign w_last = (r_state == RUN) && (r_beat_cnt == CNT_W'(BLK_BEATS-1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat_cnt <= '0;
      r_idx <= '0;
      r1_valid <= 1'b0;
      r1_first <= 1'b0;
      r1_din <= '0;
      r1_idx <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      r1_valid <= bus.valid_in;
      r1_first <= bus.valid_in && (r_state == IDLE);
      r1_din <= bus.din;
      r1_idx <= w_idx;
      bus.frame_err <= (r_state == RUN) && !bus.valid_in;
      if (bus.valid_in) begin
        r_idx <= w_idx;
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
        r_state <= w_last ? IDLE : RUN;
      end else begin
        r_beat_cnt <= '0;
        r_state <= IDLE;
      end
    end
  end
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    cbfp_lane_shift u_shift (
      .i_din (r1_din[i]),
      .i_idx (r1_idx),
      .o_dout(w_dout[i]),
      .o_sat (w_sat[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out <= 1'b0;
      bus.blk_start_out <= 1'b0;
      bus.dout <= '0;
      bus.blk_idx_out <= '0;
    end else begin
      bus.valid_out <= r1_valid;
      bus.blk_start_out <= r1_valid && r1_first;
      bus.dout <= r1_valid ? w_dout : '0;
      if (r1_valid) bus.blk_idx_out <= r1_idx;
    end
  end
`ifdef CBFP_DENORM_SATCNT_EN
  // running total restarts on the first beat so it is complete on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.sat_cnt <= '0;
    else if (r1_valid) bus.sat_cnt <= (r1_first ? '0 : bus.sat_cnt) + SAT_W'($countones(w_sat));
  end
`endif
endmodule

// File: tb/tb_cbfp_denorm.sv
// tb_cbfp_denorm: directed self-checking bench for cbfp_denorm.
module tb_cbfp_denorm;
  import cbfp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  cbfp_denorm_if bus();
  cbfp_denorm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic din_arr_t fill(input int v);
    din_arr_t f;
    for (int i = 0; i < ARRAY_SIZE; i++) f[i] = DIN_SIZE'(v);
    return f;
  endfunction

  function automatic dout_arr_t fill13(input int v);
    dout_arr_t f;
    for (int i = 0; i < ARRAY_SIZE; i++) f[i] = DOUT_SIZE'(v);
    return f;
  endfunction

  task automatic step(input logic v, input din_arr_t d, input idx_t idx);
    @(negedge clk);
    bus.valid_in = v;
    bus.din = d;
    bus.blk_idx_in = idx;
  endtask

  task automatic test_reset();
    bus.valid_in = 1'b0;
    bus.din = '0;
    bus.blk_idx_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b want 0", bus.valid_out); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset dout: got %h want 0", bus.dout); end
    checks++; if (bus.blk_start_out !== 1'b0) begin errors++; $display("FAIL reset blk_start_out: got %b want 0", bus.blk_start_out); end
    checks++; if (bus.blk_idx_out !== '0) begin errors++; $display("FAIL reset blk_idx_out: got %0d want 0", bus.blk_idx_out); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b want 0", bus.frame_err); end
`ifdef CBFP_DENORM_SATCNT_EN
    checks++; if (bus.sat_cnt !== '0) begin errors++; $display("FAIL reset sat_cnt: got %0d want 0", bus.sat_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < 6; k++) begin
      int j;
      logic ev;
      step(k < 4, fill(100), idx_t'(4));
      j = k - 2;
      ev = (j >= 0) && (j < 4);
      checks++; if (bus.valid_out !== ev) begin errors++; $display("FAIL pass valid_out k=%0d: got %b want %b", k, bus.valid_out, ev); end
      checks++; if (bus.dout !== (ev ? fill13(100) : '0)) begin errors++; $display("FAIL pass dout k=%0d: got %h want lanes=%0d", k, bus.dout, ev ? 100 : 0); end
      checks++; if (bus.blk_start_out !== (j == 0)) begin errors++; $display("FAIL pass blk_start k=%0d: got %b want %b", k, bus.blk_start_out, j == 0); end
      if (ev) begin
        checks++; if (bus.blk_idx_out !== idx_t'(4)) begin errors++; $display("FAIL pass blk_idx k=%0d: got %0d want 4", k, bus.blk_idx_out); end
      end
    end
  endtask

  task automatic test_scale_sat();
    din_arr_t a_in;
    dout_arr_t a_out;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      a_in[i] = (i % 2 == 0) ? DIN_SIZE'(300) : DIN_SIZE'(-1024);
      a_out[i] = (i % 2 == 0) ? DOUT_SIZE'(4095) : DOUT_SIZE'(-4096);
    end
    for (int k = 0; k < 10; k++) begin
      int j;
      logic ev;
      step(k < 8, (k < 4) ? fill(100) : a_in, (k == 0 || k == 4) ? idx_t'(0) : idx_t'(9));
      j = k - 2;
      ev = (j >= 0) && (j < 8);
      checks++; if (bus.valid_out !== ev) begin errors++; $display("FAIL scale valid_out k=%0d: got %b want %b", k, bus.valid_out, ev); end
      if (ev) begin
        checks++; if (bus.dout !== ((j < 4) ? fill13(1600) : a_out)) begin errors++; $display("FAIL scale dout j=%0d: got %h", j, bus.dout); end
        checks++; if (bus.blk_start_out !== (j == 0 || j == 4)) begin errors++; $display("FAIL scale blk_start j=%0d: got %b want %b", j, bus.blk_start_out, j == 0 || j == 4); end
        checks++; if (bus.blk_idx_out !== idx_t'(0)) begin errors++; $display("FAIL scale blk_idx j=%0d: got %0d want 0", j, bus.blk_idx_out); end
`ifdef CBFP_DENORM_SATCNT_EN
        if (j == 3) begin
          checks++; if (bus.sat_cnt !== 7'd0) begin errors++; $display("FAIL sat_cnt block A: got %0d want 0", bus.sat_cnt); end
        end
        if (j == 7) begin
          checks++; if (bus.sat_cnt !== 7'd64) begin errors++; $display("FAIL sat_cnt block B: got %0d want 64", bus.sat_cnt); end
        end
`endif
      end
    end
`ifdef CBFP_DENORM_SATCNT_EN
    step(1'b0, fill(0), idx_t'(0));
    checks++; if (bus.sat_cnt !== 7'd64) begin errors++; $display("FAIL sat_cnt hold: got %0d want 64", bus.sat_cnt); end
`endif
  endtask

  task automatic test_rounding();
    int idxs[4] = '{6, 22, 5, 3};
    din_arr_t ins[4];
    dout_arr_t outs[4];
    ins[0] = fill(0);
    outs[0] = fill13(0);
    ins[0][0] = 11'sd3;    outs[0][0] = 13'sd1;
    ins[0][1] = -11'sd3;   outs[0][1] = -13'sd1;
    ins[0][2] = 11'sd2;    outs[0][2] = 13'sd1;
    ins[0][3] = -11'sd2;   outs[0][3] = 13'sd0;
    ins[0][4] = 11'sd1;    outs[0][4] = 13'sd0;
    ins[1] = fill(1023);   outs[1] = fill13(0);
    ins[2] = fill(1023);   outs[2] = fill13(512);
    ins[3] = fill(-1024);  outs[3] = fill13(-2048);
    for (int k = 0; k < 18; k++) begin
      int j;
      logic ev;
      step(k < 16, (k < 16) ? ins[k/4] : fill(0), (k < 16 && k % 4 == 0) ? idx_t'(idxs[k/4]) : idx_t'(0));
      j = k - 2;
      ev = (j >= 0) && (j < 16);
      checks++; if (bus.valid_out !== ev) begin errors++; $display("FAIL round valid_out k=%0d: got %b want %b", k, bus.valid_out, ev); end
      if (ev) begin
        checks++; if (bus.dout !== outs[j/4]) begin errors++; $display("FAIL round dout idx=%0d j=%0d: got %h want %h", idxs[j/4], j, bus.dout, outs[j/4]); end
        checks++; if (bus.blk_idx_out !== idx_t'(idxs[j/4])) begin errors++; $display("FAIL round blk_idx j=%0d: got %0d want %0d", j, bus.blk_idx_out, idxs[j/4]); end
      end
    end
  endtask

  task automatic test_stream();
    int idxs[4] = '{2, 4, 7, 3};
    int exps[4] = '{256, 64, 8, 128};
    int beats = 0;
    for (int k = 0; k < 34; k++) begin
      int j;
      logic ev;
      logic vin;
      vin = (k < 32) && (k % 8 < 4);
      step(vin, fill(64), (k < 32 && k % 8 == 0) ? idx_t'(idxs[k/8]) : idx_t'(0));
      j = k - 2;
      ev = (j >= 0) && (j < 32) && (j % 8 < 4);
      checks++; if (bus.valid_out !== ev) begin errors++; $display("FAIL stream valid_out k=%0d: got %b want %b", k, bus.valid_out, ev); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL stream frame_err k=%0d: got %b want 0", k, bus.frame_err); end
      if (bus.valid_out === 1'b1) beats++;
      if (ev) begin
        checks++; if (bus.dout !== fill13(exps[j/8])) begin errors++; $display("FAIL stream dout j=%0d: got %h want lanes=%0d", j, bus.dout, exps[j/8]); end
        checks++; if (bus.blk_idx_out !== idx_t'(idxs[j/8])) begin errors++; $display("FAIL stream blk_idx j=%0d: got %0d want %0d", j, bus.blk_idx_out, idxs[j/8]); end
        checks++; if (bus.blk_start_out !== (j % 8 == 0)) begin errors++; $display("FAIL stream blk_start j=%0d: got %b want %b", j, bus.blk_start_out, j % 8 == 0); end
      end
    end
    checks++; if (beats != 16) begin errors++; $display("FAIL stream beat count: got %0d want 16", beats); end
  endtask

  task automatic test_frame_err();
    for (int k = 0; k < 12; k++) begin
      int j;
      logic ev;
      logic vin;
      vin = (k < 2) || (k >= 5 && k < 9);
      step(vin, (k < 2) ? fill(5) : fill(7), (k == 0 || k == 5) ? idx_t'(4) : idx_t'(1));
      checks++; if (bus.frame_err !== (k == 3)) begin errors++; $display("FAIL ferr frame_err k=%0d: got %b want %b", k, bus.frame_err, k == 3); end
      j = k - 2;
      ev = (j == 0) || (j == 1) || (j >= 5 && j < 9);
      checks++; if (bus.valid_out !== ev) begin errors++; $display("FAIL ferr valid_out k=%0d: got %b want %b", k, bus.valid_out, ev); end
      if (ev) begin
        checks++; if (bus.dout !== fill13((j < 2) ? 5 : 7)) begin errors++; $display("FAIL ferr dout j=%0d: got %h", j, bus.dout); end
        checks++; if (bus.blk_start_out !== (j == 0 || j == 5)) begin errors++; $display("FAIL ferr blk_start j=%0d: got %b want %b", j, bus.blk_start_out, j == 0 || j == 5); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) step(1'b1, fill(100), idx_t'(0));
    checks++; if (bus.valid_out !== 1'b1 || bus.dout !== fill13(1600)) begin errors++; $display("FAIL arst pre valid/dout: got %b %h want 1 lanes=1600", bus.valid_out, bus.dout); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL arst valid_out: got %b want 0", bus.valid_out); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL arst dout: got %h want 0", bus.dout); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL arst frame_err: got %b want 0", bus.frame_err); end
    bus.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      int j;
      logic ev;
      step(k >= 1 && k < 5, fill(100), (k == 1) ? idx_t'(4) : idx_t'(0));
      j = k - 3;
      ev = (j >= 0) && (j < 4);
      checks++; if (bus.valid_out !== ev) begin errors++; $display("FAIL arst post valid_out k=%0d: got %b want %b", k, bus.valid_out, ev); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL arst post frame_err k=%0d: got %b want 0", k, bus.frame_err); end
      if (ev) begin
        checks++; if (bus.dout !== fill13(100)) begin errors++; $display("FAIL arst post dout j=%0d: got %h want lanes=100", j, bus.dout); end
        checks++; if (bus.blk_start_out !== (j == 0)) begin errors++; $display("FAIL arst post blk_start j=%0d: got %b want %b", j, bus.blk_start_out, j == 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_scale_sat();
    test_rounding();
    test_stream();
    test_frame_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cbfp_denorm.md
Name: cbfp_denorm

Overview:
- Sits directly downstream of the CBFP normaliser in the FFT pipeline.
- Consumes 16 lanes per clock of 11-bit block-normalised mantissas, framed as 64-sample blocks of 4 beats, plus one per-block shift index (zero count).
- Restores every lane to a common fixed-point scale with round-half-up and saturation.
- Output drives the next butterfly stage.

Parameters:
- ARRAY_SIZE, 16, lanes per beat
- DIN_SIZE, 11, input mantissa width (signed)
- DOUT_SIZE, 13, output width (signed)
- IDX_SIZE, 5, block shift-index width (unsigned, legal 0..22)
- BASE, 4, index at which the output equals the input (no shift)
- BLK_BEATS, 4, beats per block

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  beat valid
- din  in  ARRAY_SIZE x DIN_SIZE  signed mantissas
- blk_idx_in  in  IDX_SIZE  block shift index; sampled only on the first beat of a block
- valid_out  out  1  output beat valid
- blk_start_out  out  1  high on the first output beat of each block
- dout  out  ARRAY_SIZE x DOUT_SIZE  signed denormalised lanes
- blk_idx_out  out  IDX_SIZE  index of the block currently on the output
- frame_err  out  1  one-cycle pulse on a truncated block

Behaviour:
- Reset: all outputs 0; beat_cnt = 0; state IDLE. Asserting rst mid-block discards the in-flight block and clears the pipeline with no output.
- FSM, two states:
  - IDLE: waiting for a first beat. valid_in=1 -> latch blk_idx_in, beat_cnt=1, go to RUN.
  - RUN: valid_in=1 -> beat_cnt++. After beat BLK_BEATS-1, beat_cnt wraps to 0 and the FSM returns to IDLE.
  - RUN with valid_in=0: frame_err pulses 1 cycle (same cycle the gap is seen), beat_cnt=0, go to IDLE. Beats already accepted still emerge.
- Gaps between blocks (valid_in low while IDLE) are legal for any length.
- Back-to-back blocks: a new first beat in the cycle right after the last beat is accepted, with no bubble.
- Pipeline, 2 cycles of latency: an input beat at edge N appears on dout/valid_out at edge N+2.
  - Stage 1 registers lanes, the latched index and the first-beat flag.
  - Stage 2 registers the shifted result.
- Arithmetic per lane, with s = idx - BASE:
  - s <= 0: left shift by -s, then saturate to [-2^(DOUT_SIZE-1), 2^(DOUT_SIZE-1)-1].
  - s > 0: add 2^(s-1), then arithmetic right shift by s. The intermediate is wide enough that it never overflows. The result is 0 once s exceeds DIN_SIZE for non-negative inputs.
- An index > 22 is treated as 22.
- blk_idx_out and blk_start_out travel with their beat.
- valid_out=0 beats drive dout=0.

Optional Feature:
- Macro: CBFP_DENORM_SATCNT_EN.
- Enabled:
  - Adds output port sat_cnt [6:0], the number of lanes saturated in the block.
  - sat_cnt is valid in the cycle of the block's last output beat and otherwise holds its value.
  - sat_cnt resets to 0 on rst and restarts on each blk_start_out.
- Disabled: the port and counter are absent, and saturation is silent.

Decomposition:
- Package cbfp_pkg holds:
  - the width constants (DIN_SIZE, DOUT_SIZE, IDX_SIZE, BLK_BEATS)
  - typedefs for the lane array of mantissas and the lane array of outputs
  - the maximum legal index (22)
- Sub-module cbfp_lane_shift: purely combinational shift/round/saturate for one lane, outputs value plus a sat flag. It is instantiated ARRAY_SIZE times inside stage 2.

Test Plan:
1. Block with all lanes = 100, idx = 4 (BASE) -> 4 valid_out beats all = 100. blk_start_out high on beat 0 only. First output 2 cycles after the first input.
2. Lanes = 100, idx = 0 -> 1600. Lanes = 300, idx = 0 -> 4095 (sat). Lanes = -1024, idx = 0 -> -4096 (sat). With CBFP_DENORM_SATCNT_EN, the 300/-1024 block gives sat_cnt = 64.
3. Rounding at idx = 6: 3 -> 1, -3 -> -1, 2 -> 1, -2 -> 0, 1 -> 0. At idx = 22, 1023 -> 0.
4. Stream of 4 blocks separated by 4-cycle valid_in-low gaps -> 16 output beats with correct per-block index. idx changes on blk_idx_in during beats 1..3 are ignored.
5. valid_in dropped after beat 2 -> frame_err pulses once, 2 output beats emitted. The next first beat starts a fresh block with blk_start_out.
6. rst asserted mid-block, asynchronously between edges -> valid_out, dout and frame_err go to 0 immediately. After rst release the next block processes normally.
